truth_table_sweeper: RTL and testbench

Sequential stimulus/capture stage that sits directly upstream of the 4-input combinational `gate` block and also consumes its output. On `start`, the block drives the gate inputs `a`, `b`, `c` and `d` through all 16 input vectors in ascending order and waits a programmable settle time. It then samples `y` and presents each row on a valid/ready stream, assembling the complete truth table into a 16-bit word. It replaces the open-loop exhaustive sweep with a synthesizable, cycle-exact sequencer.

---
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 tb/tb_truth_table_sweeper.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives a 4-input gate through all 16 vectors,
// samples y after a settle time and streams each row out.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        y,
  output logic        row_valid,
  input  logic        row_ready,
  output logic [3:0]  row_index,
  output logic        row_y,
  output logic [15:0] table_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("SETTLE must be in 1..15");
  end

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        row_y_q, row_y_d;
  logic [15:0] table_q, table_d;

  // state register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      row_y_q <= 1'b0;
      table_q <= 16'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      row_y_q <= row_y_d;
      table_q <= table_d;
    end
  end

  // sweep sequencing: drive, settle, capture, hand off, advance
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    row_y_d = row_y_q;
    table_d = table_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 4'd0;
          cnt_d   = 4'd0;
          table_d = 16'd0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          row_y_d        = y;
          table_d[vec_q] = y;
          state_d        = S_EMIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_EMIT: begin
        if (row_ready) begin
          if (vec_q == 4'hF) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + 4'd1;
            cnt_d   = 4'd0;
            state_d = S_DRIVE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs decode directly from flops
  always_comb begin
    a         = vec_q[3];
    b         = vec_q[2];
    c         = vec_q[1];
    d         = vec_q[0];
    row_index = vec_q;
    row_y     = row_y_q;
    table_out = table_q;
    row_valid = (state_q == S_EMIT);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized and directed sweeps of two
// instances (SETTLE=1 and SETTLE=3) against a behavioural gate model.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  logic start_v, rdy_v, sel;
  logic start1, start3, rdy1, rdy3;
  logic [15:0] g1, g3;

  logic a1, b1, c1, d1, v1, ry1, bz1, dn1;
  logic [3:0] ix1;
  logic [15:0] tb1;
  logic a3, b3, c3, d3, v3, ry3, bz3, dn3;
  logic [3:0] ix3;
  logic [15:0] tb3;
  logic y1, y3;

  logic oa, ob, oc, od, o_valid, o_rowy, o_busy, o_done;
  logic [3:0] o_index;
  logic [15:0] o_table;

  int checks = 0;
  int errors = 0;

  assign y1 = g1[{a1, b1, c1, d1}];
  assign y3 = g3[{a3, b3, c3, d3}];

  always_comb begin
    start1 = start_v & ~sel;
    start3 = start_v & sel;
    rdy1   = rdy_v & ~sel;
    rdy3   = rdy_v & sel;
    oa      = sel ? a3 : a1;
    ob      = sel ? b3 : b1;
    oc      = sel ? c3 : c1;
    od      = sel ? d3 : d1;
    o_valid = sel ? v3 : v1;
    o_rowy  = sel ? ry3 : ry1;
    o_busy  = sel ? bz3 : bz1;
    o_done  = sel ? dn3 : dn1;
    o_index = sel ? ix3 : ix1;
    o_table = sel ? tb3 : tb1;
  end

  truth_table_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .y(y1),
    .row_valid(v1), .row_ready(rdy1), .row_index(ix1),
    .row_y(ry1), .table_out(tb1), .busy(bz1), .done(dn1)
  );

  truth_table_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .a(a3), .b(b3), .c(c3), .d(d3), .y(y3),
    .row_valid(v3), .row_ready(rdy3), .row_index(ix3),
    .row_y(ry3), .table_out(tb3), .busy(bz3), .done(dn3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_and_or();
    logic [15:0] t;
    int va, vb, vc, vd;
    t = 16'd0;
    for (int i = 0; i < 16; i++) begin
      va = (i / 8) % 2;
      vb = (i / 4) % 2;
      vc = (i / 2) % 2;
      vd = i % 2;
      t[i] = ((va * vb) + (vc * vd)) > 0;
    end
    return t;
  endfunction

  // Runs one sweep on the selected instance and gathers observations.
  // Cycle n is the clock period following start edge n-1.
  task automatic run_sweep(
    input  int stall_row, input int stall_len, input int low_pct,
    input  int st_a, input int st_b, input bit st_done,
    output int nrows, output int ord_bad, output int y_bad,
    output int hold_bad, output int busy_bad,
    output int done_cyc, output int done_cnt, output int stalls,
    output int acc_span,
    output logic [15:0] tab_done, output logic [15:0] tab_c1);
    int n, stall_left, first_acc, last_acc;
    bit prev_hold, r, exp_busy;
    logic [3:0] p_idx;
    logic p_y;
    logic [15:0] gtab;
    gtab = sel ? g3 : g1;
    nrows = 0; ord_bad = 0; y_bad = 0; hold_bad = 0; busy_bad = 0;
    done_cyc = -1; done_cnt = 0; stalls = 0; acc_span = -1;
    tab_done = 16'hxxxx; tab_c1 = 16'hxxxx;
    first_acc = -1; last_acc = -1;
    stall_left = stall_len; prev_hold = 0; p_idx = 4'd0; p_y = 1'b0;
    @(posedge clk);
    #1 start_v = 1'b1; rdy_v = 1'b1;
    @(posedge clk);
    #1 start_v = 1'b0;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (n == 1) tab_c1 = o_table;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = n;
          tab_done = o_table;
        end
      end
      exp_busy = (done_cyc < 0) || (n <= done_cyc);
      if (o_busy !== exp_busy) busy_bad++;
      if ({oa, ob, oc, od} !== o_index) hold_bad++;
      if (prev_hold) begin
        if (!o_valid || o_index !== p_idx || o_rowy !== p_y) hold_bad++;
      end
      start_v = (n == st_a) || (n == st_b) || (st_done && o_done);
      if (o_valid && int'(o_index) == stall_row && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else if (low_pct > 0) begin
        r = ($urandom_range(99, 0) >= low_pct);
      end else begin
        r = 1'b1;
      end
      rdy_v = r;
      if (o_valid && r) begin
        if (o_index !== nrows[3:0]) ord_bad++;
        if (o_rowy !== gtab[o_index]) y_bad++;
        if (first_acc < 0) first_acc = n;
        last_acc = n;
        nrows++;
      end
      if (o_valid && !r) stalls++;
      prev_hold = o_valid && !r;
      p_idx = o_index;
      p_y = o_rowy;
      if (done_cyc > 0 && n >= done_cyc + 3) break;
    end
    if (first_acc >= 0) acc_span = last_acc - first_acc;
    #1 start_v = 1'b0;
    rdy_v = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({a1, b1, c1, d1, v1, ix1, ry1, tb1, bz1, dn1} !== 26'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %h want 0",
               {a1, b1, c1, d1, v1, ix1, ry1, tb1, bz1, dn1});
    end
    checks++;
    if ({a3, b3, c3, d3, v3, ix3, ry3, tb3, bz3, dn3} !== 26'd0) begin
      errors++;
      $display("FAIL reset_dut3 got %h want 0",
               {a3, b3, c3, d3, v3, ix3, ry3, tb3, bz3, dn3});
    end
    start_v = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_v = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bz1 !== 1'b0 || bz3 !== 1'b0 || v1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy %b/%b valid %b want 0", bz1, bz3, v1);
    end
  endtask

  task automatic test_basic();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span;
    logic [15:0] td, tc;
    sel = 1'b0;
    g1 = ref_and_or();
    run_sweep(-1, 0, 0, 0, 0, 0, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
    checks++;
    if (nr != 16 || ob_ != 0 || yb != 0) begin
      errors++;
      $display("FAIL basic_rows got n=%0d ord=%0d y=%0d want 16/0/0", nr, ob_, yb);
    end
    checks++;
    if (td !== 16'hF888 || td !== g1) begin
      errors++;
      $display("FAIL basic_table got %h want F888", td);
    end
    checks++;
    if (dc != 33 || dcnt != 1) begin
      errors++;
      $display("FAIL basic_done got cyc=%0d cnt=%0d want 33/1", dc, dcnt);
    end
    checks++;
    if (hb != 0 || bb != 0 || tc !== 16'd0) begin
      errors++;
      $display("FAIL basic_misc got hold=%0d busy=%0d tab1=%h want 0", hb, bb, tc);
    end
    checks++;
    if (span != 30) begin
      errors++;
      $display("FAIL basic_period got span=%0d want 30", span);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (tb1 !== 16'hF888) begin
      errors++;
      $display("FAIL basic_hold_table got %h want F888", tb1);
    end
  endtask

  task automatic test_backpressure();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span;
    logic [15:0] td, tc;
    sel = 1'b0;
    g1 = ref_and_or();
    run_sweep(5, 5, 0, 0, 0, 0, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
    checks++;
    if (st != 5 || hb != 0) begin
      errors++;
      $display("FAIL bp_hold got stalls=%0d hold=%0d want 5/0", st, hb);
    end
    checks++;
    if (nr != 16 || ob_ != 0 || yb != 0) begin
      errors++;
      $display("FAIL bp_rows got n=%0d ord=%0d y=%0d want 16/0/0", nr, ob_, yb);
    end
    checks++;
    if (dc != 38 || td !== 16'hF888) begin
      errors++;
      $display("FAIL bp_done got cyc=%0d tab=%h want 38/F888", dc, td);
    end
  endtask

  task automatic test_settle();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span;
    logic [15:0] td, tc;
    sel = 1'b1;
    g3 = 16'hFFFF;
    run_sweep(-1, 0, 0, 0, 0, 0, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
    checks++;
    if (span != 60 || nr != 16) begin
      errors++;
      $display("FAIL settle_period got span=%0d n=%0d want 60/16", span, nr);
    end
    checks++;
    if (td !== 16'hFFFF || yb != 0) begin
      errors++;
      $display("FAIL settle_table got %h ybad=%0d want FFFF", td, yb);
    end
    checks++;
    if (dc != 65 || dcnt != 1 || bb != 0) begin
      errors++;
      $display("FAIL settle_done got cyc=%0d cnt=%0d busy=%0d want 65/1/0", dc, dcnt, bb);
    end
    sel = 1'b0;
  endtask

  task automatic test_start_busy();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span;
    logic [15:0] td, tc;
    sel = 1'b0;
    g1 = ref_and_or();
    run_sweep(-1, 0, 0, 6, 20, 1, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
    checks++;
    if (nr != 16 || ob_ != 0 || td !== 16'hF888) begin
      errors++;
      $display("FAIL busy_start_result got n=%0d ord=%0d tab=%h want 16/0/F888", nr, ob_, td);
    end
    checks++;
    if (dc != 33 || dcnt != 1 || bb != 0) begin
      errors++;
      $display("FAIL busy_start_done got cyc=%0d cnt=%0d busy=%0d want 33/1/0", dc, dcnt, bb);
    end
  endtask

  task automatic test_back_to_back();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span;
    logic [15:0] td, tc;
    sel = 1'b0;
    g1 = ref_and_or();
    run_sweep(-1, 0, 0, 0, 0, 0, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
    checks++;
    if (tc !== 16'd0 || td !== 16'hF888 || dc != 33) begin
      errors++;
      $display("FAIL b2b got tab1=%h tab=%h cyc=%0d want 0/F888/33", tc, td, dc);
    end
  endtask

  task automatic test_reset_mid();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span, k;
    logic [15:0] td, tc;
    bit hit;
    sel = 1'b0;
    g1 = ref_and_or();
    @(posedge clk);
    #1 start_v = 1'b1; rdy_v = 1'b1;
    @(posedge clk);
    #1 start_v = 1'b0;
    hit = 0;
    k = 0;
    while (k < 100 && !hit) begin
      @(negedge clk);
      k++;
      if (v1 && ix1 == 4'd7) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_reach got timeout want row 7");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a1, b1, c1, d1, v1, ix1, ry1, tb1, bz1, dn1} !== 26'd0) begin
      errors++;
      $display("FAIL rstmid_async got %h want 0",
               {a1, b1, c1, d1, v1, ix1, ry1, tb1, bz1, dn1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bz1 !== 1'b0 || v1 !== 1'b0 || ix1 !== 4'd0 || tb1 !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_quiet got busy=%b valid=%b idx=%h tab=%h want 0",
               bz1, v1, ix1, tb1);
    end
    run_sweep(-1, 0, 0, 0, 0, 0, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
    checks++;
    if (td !== 16'hF888 || dc != 33 || nr != 16) begin
      errors++;
      $display("FAIL rstmid_sweep got tab=%h cyc=%0d n=%0d want F888/33/16", td, dc, nr);
    end
  endtask

  task automatic test_zero();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span;
    logic [15:0] td, tc;
    sel = 1'b0;
    g1 = 16'h0000;
    run_sweep(-1, 0, 0, 0, 0, 0, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
    checks++;
    if (td !== 16'h0000 || yb != 0 || nr != 16) begin
      errors++;
      $display("FAIL zero_table got tab=%h ybad=%0d n=%0d want 0/0/16", td, yb, nr);
    end
    checks++;
    if (dc != 33 || dcnt != 1) begin
      errors++;
      $display("FAIL zero_done got cyc=%0d cnt=%0d want 33/1", dc, dcnt);
    end
  endtask

  task automatic test_random();
    int nr, ob_, yb, hb, bb, dc, dcnt, st, span, s, exp_dc;
    logic [15:0] td, tc, gt;
    for (int it = 0; it < 4; it++) begin
      sel = it[0];
      gt = 16'($urandom);
      if (sel) g3 = gt; else g1 = gt;
      s = sel ? 3 : 1;
      run_sweep(-1, 0, 35, 0, 0, 0, nr, ob_, yb, hb, bb, dc, dcnt, st, span, td, tc);
      exp_dc = 16 * (s + 1) + 1 + st;
      checks++;
      if (nr != 16 || ob_ != 0 || yb != 0 || hb != 0) begin
        errors++;
        $display("FAIL rand_rows it=%0d got n=%0d ord=%0d y=%0d hold=%0d want 16/0/0/0",
                 it, nr, ob_, yb, hb);
      end
      checks++;
      if (td !== gt || dc != exp_dc || dcnt != 1 || bb != 0) begin
        errors++;
        $display("FAIL rand_result it=%0d got tab=%h cyc=%0d cnt=%0d want %h/%0d/1",
                 it, td, dc, dcnt, gt, exp_dc);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    start_v = 1'b0;
    rdy_v = 1'b1;
    sel = 1'b0;
    g1 = 16'd0;
    g3 = 16'd0;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_settle();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
